// File: rtl/scan_sequencer.sv
// ============================================================================
//  Module      : scan_sequencer
//  Description : Steps a 3-to-8 decoder through the masked slots in ascending
//                order, holding each slot for a programmable dwell time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               en,
    output logic [2:0]         sel,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [DWELL_W-1:0] c_cnt_one  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] c_cnt_zero = '0;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [7:0]         r_mask_q;
    logic [DWELL_W-1:0] r_dwell_q;
    logic [DWELL_W-1:0] r_cnt;
    logic [2:0]         r_sel;

    logic               w_mask_nz;
    logic               w_start_ok;
    logic               w_slot_end;
    logic               w_frame_end;
    logic [2:0]         w_next_slot;
    logic [2:0]         w_first_slot;

    // Lowest set bit of a mask; only meaningful for a nonzero mask.
    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        f_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                f_lowest = 3'(i);
            end
        end
    endfunction

    // Next set bit searching upward from cur+1 with wrap; offset 8 lands on
    // cur itself, which is how a single-bit mask re-enters its own slot.
    function automatic logic [2:0] f_next_slot(input logic [7:0] m,
                                               input logic [2:0] cur);
        logic [2:0] idx;
        logic       found;
        f_next_slot = cur;
        found       = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = cur + 3'(k);
            if (!found && m[idx]) begin
                f_next_slot = idx;
                found       = 1'b1;
            end
        end
    endfunction

    assign w_mask_nz    = |mask;
    assign w_first_slot = f_lowest(mask);
    assign w_next_slot  = f_next_slot(r_mask_q, r_sel);
    assign w_start_ok   = (r_state == ST_IDLE) && start && !stop && w_mask_nz;
    assign w_slot_end   = (r_state == ST_SCAN) && (r_cnt == r_dwell_q);
    assign w_frame_end  = w_slot_end && (w_next_slot <= r_sel);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_frame_end && !w_mask_nz) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Slot, dwell counter and latched mask/dwell
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask_q  <= 8'h00;
            r_dwell_q <= c_cnt_zero;
            r_cnt     <= c_cnt_zero;
            r_sel     <= 3'd0;
        end else if (stop) begin
            r_cnt <= c_cnt_zero;
            r_sel <= 3'd0;
        end else if (w_start_ok) begin
            r_mask_q  <= mask;
            r_dwell_q <= dwell;
            r_cnt     <= c_cnt_zero;
            r_sel     <= w_first_slot;
        end else if (r_state == ST_SCAN) begin
            if (w_slot_end) begin
                r_cnt     <= c_cnt_zero;
                r_dwell_q <= dwell;
                if (w_frame_end) begin
                    // A new frame picks up whatever mask is presented now.
                    r_mask_q <= mask;
                    r_sel    <= w_mask_nz ? w_first_slot : 3'd0;
                end else begin
                    r_sel <= w_next_slot;
                end
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // Output logic
    always_comb begin
        en         = (r_state == ST_SCAN);
        busy       = (r_state == ST_SCAN);
        sel        = r_sel;
        frame_done = w_frame_end;
    end

endmodule

`default_nettype wire
